// File: rtl/cpu15_pkg.sv
// Shared definitions for the cpu15 core: datapath widths, opcode field and fetch FSM states.
package cpu15_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 14;
  localparam int OPC_LSB = 11;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_ST  = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h3;
  localparam logic [OPC_W-1:0] OP_BR  = 4'h8;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one ROM read per fetch strobe, tracks the PC
// (including branches that land while a read is outstanding) and stops on HLT.
module fetch_unit
  import cpu15_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 8'h00,
  parameter logic [OPC_W-1:0]  OP_HLT_CODE = OP_HLT
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               CLK_FT,
  input  logic               CLK_WB,
  input  logic               BR_TAKEN,
  input  logic [ADDR_W-1:0]  BR_ADDR,
  output logic               ROM_REQ,
  output logic [ADDR_W-1:0]  ROM_ADDR,
  input  logic               ROM_ACK,
  input  logic [INSTR_W-1:0] ROM_DATA,
  output logic [INSTR_W-1:0] IR,
  output logic [ADDR_W-1:0]  PC,
  output logic               IR_VALID,
  output logic               STALL,
  output logic               HALTED
);

  fetch_state_t       state, state_nxt;
  logic [ADDR_W-1:0]  pc_q, rom_addr_q, pend_addr_q;
  logic [INSTR_W-1:0] ir_q;
  logic               rom_req_q, ir_vld_q, pend_vld_q;
  logic               br;
  logic               ack_hlt;

  assign br      = CLK_WB & BR_TAKEN;
  assign ack_hlt = (opcode_of(ROM_DATA) == OP_HLT_CODE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (CLK_FT) state_nxt = S_REQ;
      S_REQ:   if (ROM_ACK) state_nxt = ack_hlt ? S_HALT : S_IDLE;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A branch seen while the read is in flight is parked until the ack retires it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q        <= RESET_PC;
      rom_addr_q  <= '0;
      rom_req_q   <= 1'b0;
      ir_q        <= '0;
      ir_vld_q    <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (br) pc_q <= BR_ADDR;
          if (CLK_FT) begin
            rom_addr_q <= br ? BR_ADDR : pc_q;
            rom_req_q  <= 1'b1;
            ir_vld_q   <= 1'b0;
          end
        end
        S_REQ: begin
          if (ROM_ACK) begin
            ir_q       <= ROM_DATA;
            rom_req_q  <= 1'b0;
            ir_vld_q   <= 1'b1;
            pend_vld_q <= 1'b0;
            if (br)              pc_q <= BR_ADDR;
            else if (pend_vld_q) pc_q <= pend_addr_q;
            else                 pc_q <= pc_q + 8'd1;
          end else if (br) begin
            pend_vld_q  <= 1'b1;
            pend_addr_q <= BR_ADDR;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ROM_REQ  = rom_req_q;
    ROM_ADDR = rom_addr_q;
    IR       = ir_q;
    PC       = pc_q;
    IR_VALID = ir_vld_q;
    STALL    = rom_req_q;
    HALTED   = (state == S_HALT);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a cycle-level reference model.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CLK_FT = 1'b0, CLK_WB = 1'b0, BR_TAKEN = 1'b0, ROM_ACK = 1'b0;
  logic [7:0]  BR_ADDR = 8'h00;
  logic [15:0] ROM_DATA = 16'h0000;
  logic        ROM_REQ, IR_VALID, STALL, HALTED;
  logic [7:0]  ROM_ADDR, PC;
  logic [15:0] IR;

  fetch_unit dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLK_FT(CLK_FT), .CLK_WB(CLK_WB),
    .BR_TAKEN(BR_TAKEN), .BR_ADDR(BR_ADDR), .ROM_REQ(ROM_REQ), .ROM_ADDR(ROM_ADDR),
    .ROM_ACK(ROM_ACK), .ROM_DATA(ROM_DATA), .IR(IR), .PC(PC),
    .IR_VALID(IR_VALID), .STALL(STALL), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: "busy" means a read is outstanding, "halted" is terminal.
  int          m_pc, m_addr, m_paddr;
  bit          m_busy, m_vld, m_halt, m_pend;
  logic [15:0] m_ir;

  task automatic model_reset();
    m_pc = 0; m_addr = 0; m_paddr = 0;
    m_busy = 0; m_vld = 0; m_halt = 0; m_pend = 0; m_ir = 16'h0000;
  endtask

  task automatic model_step(input bit ft, input bit wb, input bit bt, input int ba,
                            input bit ack, input logic [15:0] data);
    bit take;
    take = wb && bt;
    if (m_halt) return;
    if (!m_busy) begin
      if (ft) begin
        m_addr = take ? ba : m_pc;
        m_busy = 1; m_vld = 0;
      end
      if (take) m_pc = ba;
    end else if (ack) begin
      m_ir = data; m_busy = 0; m_vld = 1;
      if (take)        m_pc = ba;
      else if (m_pend) m_pc = m_paddr;
      else             m_pc = (m_pc + 1) % 256;
      m_pend = 0;
      if (data[14:11] == 4'hF) m_halt = 1;
    end else if (take) begin
      m_pend = 1; m_paddr = ba;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rom_req"},  {15'd0, ROM_REQ},  {15'd0, m_busy});
    chk({tag, ".stall"},    {15'd0, STALL},    {15'd0, m_busy});
    chk({tag, ".rom_addr"}, {8'd0, ROM_ADDR},  16'(m_addr));
    chk({tag, ".pc"},       {8'd0, PC},        16'(m_pc));
    chk({tag, ".ir"},       IR,                m_ir);
    chk({tag, ".ir_valid"}, {15'd0, IR_VALID}, {15'd0, m_vld});
    chk({tag, ".halted"},   {15'd0, HALTED},   {15'd0, m_halt});
  endtask

  task automatic cyc(input string tag, input bit ft, input bit wb, input bit bt,
                     input logic [7:0] ba, input bit ack, input logic [15:0] data);
    @(negedge CLK);
    CLK_FT = ft; CLK_WB = wb; BR_TAKEN = bt; BR_ADDR = ba; ROM_ACK = ack; ROM_DATA = data;
    @(posedge CLK);
    model_step(ft, wb, bt, int'(ba), ack, data);
    #1 check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(negedge CLK);
    CLK_FT = 0; CLK_WB = 0; BR_TAKEN = 0; ROM_ACK = 0;
    RESET_N = 1'b1;
  endtask

  initial begin
    logic [15:0] d;
    bit ft, wb, bt, ack;
    logic [7:0] ba;

    model_reset();
    #1 check_all("reset");
    #20 RESET_N = 1'b1;

    // Basic fetch with a 3-cycle ROM wait
    cyc("ft", 1, 0, 0, 8'h00, 0, 16'h0);
    chk("basic.addr", {8'd0, ROM_ADDR}, 16'h0000);
    cyc("wait1", 0, 0, 0, 8'h00, 0, 16'h0);
    cyc("wait2", 0, 0, 0, 8'h00, 0, 16'h0);
    chk("basic.stall", {15'd0, STALL}, 16'h0001);
    cyc("ack", 0, 0, 0, 8'h00, 1, 16'h1234);
    chk("basic.ir", IR, 16'h1234);
    chk("basic.pc", {8'd0, PC}, 16'h0001);

    // Branch in IDLE then fetch
    cyc("br40", 0, 1, 1, 8'h40, 0, 16'h0);
    cyc("ft40", 1, 0, 0, 8'h00, 0, 16'h0);
    chk("br40.addr", {8'd0, ROM_ADDR}, 16'h0040);
    cyc("ack40", 0, 0, 0, 8'h00, 1, 16'h0101);
    chk("br40.pc", {8'd0, PC}, 16'h0041);

    // PC wrap at 8'hFF
    cyc("brff", 0, 1, 1, 8'hFF, 0, 16'h0);
    cyc("ftff", 1, 0, 0, 8'h00, 0, 16'h0);
    cyc("ackff", 0, 0, 0, 8'h00, 1, 16'h0202);
    chk("wrap.pc", {8'd0, PC}, 16'h0000);

    // Fetch and branch in the same IDLE cycle: branch target is fetched
    cyc("ftbr80", 1, 1, 1, 8'h80, 0, 16'h0);
    chk("same.addr", {8'd0, ROM_ADDR}, 16'h0080);
    cyc("ack80", 0, 0, 0, 8'h00, 1, 16'h0303);
    chk("same.pc", {8'd0, PC}, 16'h0081);

    // Branch while a request is outstanding, ignored FT, then ack
    cyc("ftp", 1, 0, 0, 8'h00, 0, 16'h0);
    cyc("brp20", 0, 1, 1, 8'h20, 0, 16'h0);
    cyc("ftinreq", 1, 0, 0, 8'h00, 0, 16'h0);
    cyc("ackp", 0, 0, 0, 8'h00, 1, 16'h0404);
    chk("pend.pc", {8'd0, PC}, 16'h0020);

    // Ack outside REQ ignored
    cyc("strayack", 0, 0, 0, 8'h00, 1, 16'hBEEF);

    // Reset mid-request, then a stray ack
    cyc("ftrst", 1, 0, 0, 8'h00, 0, 16'h0);
    do_reset("midreq_rst");
    cyc("postrst_ack", 0, 0, 0, 8'h00, 1, 16'h5555);
    chk("rst.ir", IR, 16'h0000);
    chk("rst.req", {15'd0, ROM_REQ}, 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (m_halt) do_reset("rand_rst");
      ft  = ($urandom_range(0, 2) == 0);
      wb  = ($urandom_range(0, 3) == 0);
      bt  = $urandom_range(0, 1);
      ba  = 8'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      d   = 16'($urandom);
      if (d[14:11] == 4'hF && $urandom_range(0, 29) != 0) d[11] = 1'b0;
      if (m_busy && ack) wb = 0;
      cyc("rand", ft, wb, bt, ba, ack, d);
    end

    // Halt: fetch stops, all inputs ignored
    do_reset("pre_hlt_rst");
    cyc("ft_h", 1, 0, 0, 8'h00, 0, 16'h0);
    cyc("ack_hlt", 0, 0, 0, 8'h00, 1, 16'h7800);
    chk("hlt.halted", {15'd0, HALTED}, 16'h0001);
    chk("hlt.stall", {15'd0, STALL}, 16'h0000);
    cyc("ft_after_hlt", 1, 0, 0, 8'h00, 0, 16'h0);
    chk("hlt.noreq", {15'd0, ROM_REQ}, 16'h0000);
    cyc("br_after_hlt", 1, 1, 1, 8'h33, 1, 16'h1111);
    chk("hlt.pc", {8'd0, PC}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
